// File: rtl/instr_encoder_pkg.sv
// Shared instruction definitions for the encoder: opcodes, field bit positions
// and the request payload that feeds the encoder.
package instr_encoder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned ADDR_W = 8;

  // Opcodes; NOP must stay at zero so the idle word decodes as a no-op
  localparam logic [OP_W-1:0] NOP   = 6'd0;
  localparam logic [OP_W-1:0] ADD   = 6'd1;
  localparam logic [OP_W-1:0] ADDI  = 6'd2;
  localparam logic [OP_W-1:0] LOAD  = 6'd3;
  localparam logic [OP_W-1:0] LOADI = 6'd4;
  localparam logic [OP_W-1:0] STORE = 6'd5;

  localparam int unsigned OP_HI  = 31;
  localparam int unsigned OP_LO  = 26;
  localparam int unsigned F1_HI  = 25;
  localparam int unsigned F1_LO  = 21;
  localparam int unsigned F2_HI  = 20;
  localparam int unsigned F2_LO  = 16;
  localparam int unsigned F3_HI  = 15;
  localparam int unsigned F3_LO  = 11;
  localparam int unsigned SH_HI  = 10;
  localparam int unsigned SH_LO  = 6;
  localparam int unsigned FN_HI  = 5;
  localparam int unsigned FN_LO  = 0;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
  } instr_req_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      NOP, ADD, ADDI, LOAD, LOADI, STORE: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO for encoded words; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate occupancy counter.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into datapath words, buffers them and
// issues one per cycle through a registered output stage (NOP word when idle).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  output logic [WORD_W-1:0] instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  issued,
  output logic              err_illegal
);

  instr_req_t        w_req;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_consume;
  logic              w_load;

  logic [WORD_W-1:0] r_instr;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_issued;
  logic              r_err;

  assign w_req = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd, imm: in_imm};

  // Encoder: only the operands an opcode uses reach the word
  always_comb begin
    w_word = '0;
    case (w_req.op)
      ADD: begin
        w_word[OP_HI:OP_LO] = w_req.op;
        w_word[F1_HI:F1_LO] = w_req.rs;
        w_word[F2_HI:F2_LO] = w_req.rt;
        w_word[F3_HI:F3_LO] = w_req.rd;
      end
      ADDI: begin
        w_word[OP_HI:OP_LO]   = w_req.op;
        w_word[F1_HI:F1_LO]   = w_req.rs;
        w_word[F2_HI:F2_LO]   = w_req.rd;
        w_word[IMM_HI:IMM_LO] = w_req.imm;
      end
      LOADI: begin
        w_word[OP_HI:OP_LO]   = w_req.op;
        w_word[F1_HI:F1_LO]   = w_req.rd;
        w_word[IMM_HI:IMM_LO] = w_req.imm;
      end
      LOAD: begin
        w_word[OP_HI:OP_LO]    = w_req.op;
        w_word[F1_HI:F1_LO]    = w_req.rd;
        w_word[ADDR_W-1:0]     = w_req.imm[ADDR_W-1:0];
      end
      STORE: begin
        w_word[OP_HI:OP_LO]    = w_req.op;
        w_word[F1_HI:F1_LO]    = w_req.rs;
        w_word[ADDR_W-1:0]     = w_req.imm[ADDR_W-1:0];
      end
      default: w_word = '0;
    endcase
  end

  // Ready follows registered fullness only, so a same-cycle pop never frees a slot
  assign in_ready  = !w_full;
  assign w_accept  = in_valid && !w_full;
  assign w_consume = r_out_valid && out_ready;
  assign w_load    = !w_empty && (!r_out_valid || out_ready);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_accept),
    .i_din   (w_word),
    .i_pop   (w_load),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_instr     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_instr     <= w_head;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_instr     <= '0;
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_issued <= '0;
    end else if (w_consume) begin
      r_issued <= r_issued + CNT_W'(1);
    end
  end

  // Sticky until reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept && !is_legal_op(in_op)) begin
      r_err <= 1'b1;
    end
  end

  assign instruction = r_instr;
  assign out_valid   = r_out_valid;
  assign issued      = r_issued;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver queues expected words at each
// accept, a monitor pops and compares at every output handshake.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [31:0]       instruction;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  issued;
  logic              err_illegal;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0]      exp_q[$];
  logic [CNT_W-1:0] exp_issued;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .issued      (issued),
    .err_illegal (err_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every handshaked word and the issue count
  initial begin
    exp_issued = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        exp_issued = '0;
      end else begin
        check("issued", 32'(issued), 32'(exp_issued));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got %h expected none", instruction);
          end else begin
            check("word", instruction, exp_q.pop_front());
          end
          exp_issued = exp_issued + CNT_W'(1);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic push(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] exp);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(exp);
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL push_timeout: got no accept expected accept");
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      @(posedge clock); #1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    int n_acc;
    int n_valid;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_instr", instruction, 32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_issued", 32'(issued), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;

    // One-cycle latency for ADD
    out_ready = 1'b1;
    push(6'd1, 5'd1, 5'd2, 5'd3, 16'hFFFF, {6'd1, 5'd1, 5'd2, 5'd3, 11'b0});
    @(negedge clock);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clock);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_word", instruction, {6'd1, 5'd1, 5'd2, 5'd3, 11'b0});
    @(negedge clock);
    check("issued_one", 32'(issued), 32'd1);
    @(posedge clock); #1;

    // Field packing with dirty unused operands
    push(6'd2, 5'd4, 5'd31, 5'd5, 16'hBEEF, {6'd2, 5'd4, 5'd5, 16'hBEEF});
    push(6'd3, 5'd9, 5'd10, 5'd6, 16'h12A5, {6'd3, 5'd6, 5'd0, 16'h00A5});
    push(6'd5, 5'd7, 5'd12, 5'd11, 16'h00FF, {6'd5, 5'd7, 5'd0, 16'h00FF});
    push(6'd4, 5'd3, 5'd14, 5'd8, 16'h1234, {6'd4, 5'd8, 5'd0, 16'h1234});
    push(6'd0, 5'd21, 5'd22, 5'd23, 16'hA5A5, 32'h0);
    wait_drain();

    // Back-pressure: capacity DEPTH+1, output holds
    out_ready = 1'b0;
    n_acc = 0;
    in_valid = 1'b1; in_op = 6'd1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd0; in_imm = 16'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (!in_ready) break;
      exp_q.push_back({6'd1, 5'd1, 5'd2, 5'(n_acc), 11'b0});
      @(posedge clock); #1;
      n_acc++;
      in_rd = 5'(n_acc);
    end
    in_valid = 1'b0;
    check("fill_accepts", 32'(n_acc), 32'(DEPTH + 1));
    check("fill_hold_valid", 32'(out_valid), 32'd1);
    check("fill_hold_word", instruction, {6'd1, 5'd1, 5'd2, 5'd0, 11'b0});
    repeat (3) @(negedge clock);
    check("fill_stable_word", instruction, {6'd1, 5'd1, 5'd2, 5'd0, 11'b0});
    @(posedge clock); #1;
    out_ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) check("ready_still_low", 32'(in_ready), 32'd0);
      if (i == 1) check("ready_rise", 32'(in_ready), 32'd1);
      if (out_valid) n_valid++;
    end
    check("drain_count", 32'(n_valid), 32'(DEPTH + 1));
    @(posedge clock); #1;

    // Illegal opcode encodes as zero and sets the sticky flag
    push(6'h3F, 5'd1, 5'd2, 5'd3, 16'hFFFF, 32'h0);
    @(negedge clock);
    check("err_set", 32'(err_illegal), 32'd1);
    @(posedge clock); #1;
    push(6'd2, 5'd1, 5'd0, 5'd2, 16'h0042, {6'd2, 5'd1, 5'd2, 16'h0042});
    wait_drain();
    check("err_sticky", 32'(err_illegal), 32'd1);

    // Reset with words buffered discards them
    out_ready = 1'b0;
    push(6'd4, 5'd0, 5'd0, 5'd1, 16'h0001, {6'd4, 5'd1, 5'd0, 16'h0001});
    push(6'd4, 5'd0, 5'd0, 5'd2, 16'h0002, {6'd4, 5'd2, 5'd0, 16'h0002});
    push(6'd4, 5'd0, 5'd0, 5'd3, 16'h0003, {6'd4, 5'd3, 5'd0, 16'h0003});
    @(negedge clock);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_instr", instruction, 32'h0);
    check("mid_rst_issued", 32'(issued), 32'd0);
    check("mid_rst_err", 32'(err_illegal), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    out_ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (out_valid) n_valid++;
    end
    check("no_stale", 32'(n_valid), 32'd0);
    @(posedge clock); #1;

    // Counter wrap (CNT_W bits)
    for (int i = 0; i < (1 << CNT_W) - 1; i++)
      push(6'd0, 5'(i), 5'(i + 1), 5'(i + 2), 16'(i * 7), 32'h0);
    wait_drain();
    check("issued_max", 32'(issued), 32'((1 << CNT_W) - 1));
    push(6'd1, 5'd30, 5'd29, 5'd28, 16'h0, {6'd1, 5'd30, 5'd29, 5'd28, 11'b0});
    wait_drain();
    check("issued_wrap", 32'(issued), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
